// File: rtl/router_inject_port.sv
// Flit transmitter feeding one router input channel: turns a packet request plus
// payload stream into head/body/tail flits and tracks per-VC credits.
module router_inject_port #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 6,
  parameter int VC_BUF_DEPTH = 8,
  parameter int MAX_BODY     = 15
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [ADDR_WIDTH-1:0]               router_address,
  input  logic                                pkt_valid,
  output logic                                pkt_ready,
  input  logic [ADDR_WIDTH-1:0]               pkt_dest,
  input  logic                                pkt_vc,
  input  logic [$clog2(MAX_BODY+1)-1:0]       pkt_len,
  input  logic                                data_valid,
  output logic                                data_ready,
  input  logic [DATA_WIDTH-1:0]               data_in,
  output logic [DATA_WIDTH+3:0]               channel_out,
  input  logic [1:0]                          flow_ctrl_in,
  output logic                                error
);

  localparam int LEN_W = $clog2(MAX_BODY + 1);
  localparam int CNT_W = $clog2(VC_BUF_DEPTH + 1);
  localparam int PAD_W = DATA_WIDTH - 2 * ADDR_WIDTH - LEN_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_dest_q, cur_dest_d;
  logic                  cur_vc_q, cur_vc_d;
  logic [LEN_W-1:0]      cur_len_q, cur_len_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [CNT_W-1:0]      cnt_q [2];
  logic [CNT_W-1:0]      cnt_d [2];
  logic                  error_q, error_d;
  logic [DATA_WIDTH+3:0] channel_q, channel_d;

  logic                  can_send;
  logic                  send;
  logic [1:0]            credit_hit;
  logic [1:0]            send_hit;
  logic [DATA_WIDTH-1:0] head_data;

  // Send eligibility uses the count registered at the start of the cycle.
  assign can_send  = (cur_vc_q ? cnt_q[1] : cnt_q[0]) != '0;
  assign head_data = {cur_dest_q, router_address, cur_len_q, {PAD_W{1'b0}}};

  always_comb begin
    state_d    = state_q;
    cur_dest_d = cur_dest_q;
    cur_vc_d   = cur_vc_q;
    cur_len_d  = cur_len_q;
    rem_d      = rem_q;
    pkt_ready  = 1'b0;
    data_ready = 1'b0;
    send       = 1'b0;
    channel_d  = '0;
    case (state_q)
      IDLE: begin
        pkt_ready = 1'b1;
        if (pkt_valid) begin
          cur_dest_d = pkt_dest;
          cur_vc_d   = pkt_vc;
          cur_len_d  = pkt_len;
          state_d    = HEAD;
        end
      end
      HEAD: begin
        if (can_send) begin
          send      = 1'b1;
          channel_d = {1'b1, 1'b1, (cur_len_q == '0), cur_vc_q, head_data};
          if (cur_len_q == '0) begin
            state_d = IDLE;
          end else begin
            rem_d   = cur_len_q;
            state_d = BODY;
          end
        end
      end
      BODY: begin
        data_ready = can_send;
        if (data_valid && can_send) begin
          send      = 1'b1;
          channel_d = {1'b1, 1'b0, (rem_q == LEN_W'(1)), cur_vc_q, data_in};
          rem_d     = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign credit_hit = {flow_ctrl_in[1] & flow_ctrl_in[0], flow_ctrl_in[1] & ~flow_ctrl_in[0]};
  assign send_hit   = {send & cur_vc_q, send & ~cur_vc_q};

  // A simultaneous send and credit on one VC cancel; an overflowing credit saturates.
  always_comb begin
    cnt_d[0] = cnt_q[0];
    cnt_d[1] = cnt_q[1];
    error_d  = error_q;
    for (int v = 0; v < 2; v++) begin
      if (credit_hit[v] && !send_hit[v]) begin
        if (cnt_q[v] == CNT_W'(VC_BUF_DEPTH)) error_d = 1'b1;
        else cnt_d[v] = cnt_q[v] + 1'b1;
      end else if (send_hit[v] && !credit_hit[v]) begin
        cnt_d[v] = cnt_q[v] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_dest_q <= '0;
      cur_vc_q   <= 1'b0;
      cur_len_q  <= '0;
      rem_q      <= '0;
      cnt_q[0]   <= CNT_W'(VC_BUF_DEPTH);
      cnt_q[1]   <= CNT_W'(VC_BUF_DEPTH);
      error_q    <= 1'b0;
      channel_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_dest_q <= cur_dest_d;
      cur_vc_q   <= cur_vc_d;
      cur_len_q  <= cur_len_d;
      rem_q      <= rem_d;
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
      error_q    <= error_d;
      channel_q  <= channel_d;
    end
  end

  assign channel_out = channel_q;
  assign error       = error_q;

endmodule
